// File: rtl/soc_estimator_mc.sv
// rtl/soc_estimator_mc.sv - multi-channel state-of-charge estimator scanning a shared ADC front-end
`timescale 1ns/1ps
module soc_estimator_mc #(
    parameter int NUM_CH     = 4,
    parameter int V_W        = 16,
    parameter int I_W        = 16,
    parameter int ACC_W      = 32,
    parameter int CLK_DIV    = 50000,
    parameter int SOC_SCALE  = 14000,
    parameter int I_GAIN     = 100,
    parameter int I_THRESH   = 5,
    parameter int REST_TICKS = 100,
    parameter int ESR_MILLI  = 1000,
    parameter int V_MIN      = 0,
    parameter int V_MAX      = 65535,
    parameter int TIMEOUT    = 255,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  meas_req,
    output logic [CH_W-1:0]       meas_ch,
    input  logic                  meas_valid,
    input  logic [V_W-1:0]        voltage,
    input  logic signed [I_W-1:0] current,
    output logic                  soc_valid,
    output logic [CH_W-1:0]       soc_ch,
    output logic [7:0]            soc,
    output logic                  soc_mode,
    output logic [NUM_CH-1:0]     fault,
    output logic                  overrun
);

    localparam int TC_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RC_W  = $clog2(REST_TICKS + 1);
    localparam int VC_W  = V_W + I_W + 11;
    localparam int SW    = ACC_W + 1;
    localparam int NUM_W = (ACC_W > V_W + 7) ? ACC_W : V_W + 7;
    localparam int DSH_W = NUM_W + 8;

    localparam logic signed [VC_W-1:0] ESR_K     = VC_W'(ESR_MILLI);
    localparam logic signed [VC_W-1:0] MILLI     = VC_W'(1000);
    localparam logic signed [VC_W-1:0] VMIN_S    = VC_W'(V_MIN);
    localparam logic signed [VC_W-1:0] VMAX_S    = VC_W'(V_MAX);
    localparam logic signed [I_W-1:0]  I_THR     = I_W'(I_THRESH);
    localparam logic signed [SW-1:0]   GAIN_S    = SW'(I_GAIN);
    localparam logic signed [SW-1:0]   ACC_MAX_S = SW'(100 * SOC_SCALE);
    localparam logic [ACC_W-1:0]       ACC_MAX   = ACC_W'(100 * SOC_SCALE);
    localparam logic [RC_W-1:0]        REST_MAX  = RC_W'(REST_TICKS);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_COMP, S_UPDATE, S_DIV, S_OUT, S_NEXT} state_t;

    state_t                  state;
    logic [TC_W-1:0]         tick_cnt;
    logic                    tick;
    logic [CH_W-1:0]         ch;
    logic [TO_W-1:0]         wait_cnt;
    logic [V_W-1:0]          v_smp;
    logic signed [I_W-1:0]   i_smp;
    logic [V_W-1:0]          v_comp;
    logic                    rest;
    logic [RC_W-1:0]         rest_next;
    logic                    mode;
    logic [ACC_W-1:0]        acc_next;
    logic [NUM_W-1:0]        rem;
    logic [DSH_W-1:0]        dsh;
    logic [7:0]              quo;
    logic [2:0]              bit_cnt;

    logic [ACC_W-1:0]        acc      [NUM_CH];
    logic [RC_W-1:0]         rest_cnt [NUM_CH];
    logic [NUM_CH-1:0]       init;

    logic signed [VC_W-1:0]  v_ext;
    logic signed [VC_W-1:0]  i_ext;
    logic signed [VC_W-1:0]  v_raw;
    logic [V_W-1:0]          v_clamp;
    logic                    is_rest;
    logic [RC_W-1:0]         rest_inc;
    logic signed [SW-1:0]    acc_sum;
    logic [ACC_W-1:0]        acc_sat;

    assign tick = (tick_cnt == TC_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TC_W'(1);
        end
    end

    // ESR compensation, rest detection and saturating coulomb update on the latched sample
    always_comb begin
        v_ext = $signed({{(VC_W - V_W){1'b0}}, v_smp});
        i_ext = $signed({{(VC_W - I_W){i_smp[I_W-1]}}, i_smp});
        v_raw = v_ext - (i_ext * ESR_K) / MILLI;
        if (v_raw < VMIN_S) begin
            v_clamp = V_W'(V_MIN);
        end else if (v_raw > VMAX_S) begin
            v_clamp = V_W'(V_MAX);
        end else begin
            v_clamp = v_raw[V_W-1:0];
        end
        is_rest  = (i_smp >= -I_THR) && (i_smp <= I_THR);
        rest_inc = (rest_cnt[ch] == REST_MAX) ? REST_MAX : rest_cnt[ch] + RC_W'(1);
        acc_sum  = $signed({1'b0, acc[ch]}) + $signed({{(SW - I_W){i_smp[I_W-1]}}, i_smp}) * GAIN_S;
        if (acc_sum < 0) begin
            acc_sat = '0;
        end else if (acc_sum > ACC_MAX_S) begin
            acc_sat = ACC_MAX;
        end else begin
            acc_sat = acc_sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ch        <= '0;
            wait_cnt  <= '0;
            v_smp     <= '0;
            i_smp     <= '0;
            v_comp    <= '0;
            rest      <= 1'b0;
            rest_next <= '0;
            mode      <= 1'b0;
            acc_next  <= '0;
            rem       <= '0;
            dsh       <= '0;
            quo       <= '0;
            bit_cnt   <= '0;
            meas_req  <= 1'b0;
            meas_ch   <= '0;
            soc_valid <= 1'b0;
            soc_ch    <= '0;
            soc       <= '0;
            soc_mode  <= 1'b0;
            fault     <= '0;
            overrun   <= 1'b0;
            init      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i]      <= '0;
                rest_cnt[i] <= '0;
            end
        end else begin
            soc_valid <= 1'b0;
            if (tick && state != S_IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        ch       <= '0;
                        meas_ch  <= '0;
                        meas_req <= 1'b1;
                        wait_cnt <= '0;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (meas_req && meas_valid) begin
                        v_smp    <= voltage;
                        i_smp    <= current;
                        meas_req <= 1'b0;
                        state    <= S_COMP;
                    end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                        fault[ch] <= 1'b1;
                        meas_req  <= 1'b0;
                        state     <= S_NEXT;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                S_COMP: begin
                    v_comp    <= v_clamp;
                    rest      <= is_rest;
                    rest_next <= is_rest ? rest_inc : '0;
                    state     <= S_COMP == S_COMP ? S_UPDATE : S_UPDATE;
                end
                S_UPDATE: begin
                    quo     <= '0;
                    bit_cnt <= '0;
                    state   <= S_DIV;
                    // Voltage path divides to a whole percent first; acc is rebuilt from it at OUT
                    if (!init[ch] || (rest && rest_next == REST_MAX)) begin
                        mode <= 1'b1;
                        rem  <= NUM_W'(v_comp - V_W'(V_MIN)) * NUM_W'(100);
                        dsh  <= DSH_W'(V_MAX - V_MIN) << 7;
                    end else begin
                        mode     <= 1'b0;
                        acc_next <= acc_sat;
                        rem      <= NUM_W'(acc_sat);
                        dsh      <= DSH_W'(SOC_SCALE) << 7;
                    end
                end
                S_DIV: begin
                    if ({8'd0, rem} >= dsh) begin
                        rem <= rem - dsh[NUM_W-1:0];
                        quo <= {quo[6:0], 1'b1};
                    end else begin
                        quo <= {quo[6:0], 1'b0};
                    end
                    dsh     <= dsh >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state <= S_OUT;
                    end
                end
                S_OUT: begin
                    soc_valid    <= 1'b1;
                    soc_ch       <= ch;
                    soc          <= quo;
                    soc_mode     <= mode;
                    acc[ch]      <= mode ? ACC_W'(quo) * ACC_W'(SOC_SCALE) : acc_next;
                    init[ch]     <= 1'b1;
                    rest_cnt[ch] <= rest_next;
                    state        <= S_NEXT;
                end
                S_NEXT: begin
                    if (ch == CH_W'(NUM_CH - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        ch       <= ch + CH_W'(1);
                        meas_ch  <= ch + CH_W'(1);
                        meas_req <= 1'b1;
                        wait_cnt <= '0;
                        state    <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_estimator_mc.sv
// tb/tb_soc_estimator_mc.sv - scoreboard and phase-table bench for soc_estimator_mc
`timescale 1ns/1ps
module tb_soc_estimator_mc;
    localparam int NCH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              meas_req;
    logic [1:0]        meas_ch;
    logic              meas_valid;
    logic [15:0]       voltage;
    logic signed [15:0] current;
    logic              soc_valid;
    logic [1:0]        soc_ch;
    logic [7:0]        soc;
    logic              soc_mode;
    logic [3:0]        fault;
    logic              overrun;

    soc_estimator_mc #(.NUM_CH(NCH), .CLK_DIV(100)) dut (
        .clk(clk), .rst_n(rst_n), .meas_req(meas_req), .meas_ch(meas_ch),
        .meas_valid(meas_valid), .voltage(voltage), .current(current),
        .soc_valid(soc_valid), .soc_ch(soc_ch), .soc(soc), .soc_mode(soc_mode),
        .fault(fault), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; int soc; int mode; } exp_t;
    typedef struct { int ticks; int v0; int i0; int exp_soc; int exp_mode; } phase_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    int     chv[NCH];
    int     chi[NCH];
    bit     dead[NCH];
    longint m_acc[NCH];
    int     m_rc[NCH];
    bit     m_init[NCH];
    int     n_out[NCH];
    int     last_soc[NCH];
    int     last_mode[NCH];
    int     exp_req_ch = 0;
    int     dead_cycles = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference estimator: integer arithmetic straight from the channel behaviour
    function automatic exp_t model(input int c, input int v, input int i);
        exp_t e;
        int   vc;
        int   sv;
        vc = v - (i * 1000) / 1000;
        if (vc < 0) vc = 0;
        if (vc > 65535) vc = 65535;
        if (i >= -5 && i <= 5) m_rc[c] = (m_rc[c] < 100) ? m_rc[c] + 1 : 100;
        else m_rc[c] = 0;
        e.ch = c;
        if (!m_init[c] || m_rc[c] == 100) begin
            sv        = (vc * 100) / 65535;
            m_acc[c]  = longint'(sv) * 14000;
            m_init[c] = 1'b1;
            e.mode    = 1;
        end else begin
            m_acc[c] = m_acc[c] + i * 100;
            if (m_acc[c] < 0) m_acc[c] = 0;
            if (m_acc[c] > 1400000) m_acc[c] = 1400000;
            e.mode = 0;
        end
        e.soc = int'(m_acc[c] / 14000);
        return e;
    endfunction

    initial begin : frontend
        int   lat;
        bit   sent;
        exp_t e;
        lat = 0;
        sent = 1'b0;
        meas_valid = 1'b0;
        voltage = '0;
        current = '0;
        forever begin
            @(negedge clk);
            if (meas_req && rst_n) begin
                if (lat == 0) begin
                    check("req_order", meas_ch, exp_req_ch);
                    exp_req_ch = (exp_req_ch + 1) % NCH;
                end
                if (dead[meas_ch]) begin
                    meas_valid = 1'b0;
                    dead_cycles++;
                end else if (!sent && lat >= int'(meas_ch) % 2) begin
                    voltage    = 16'(chv[meas_ch]);
                    current    = 16'(chi[meas_ch]);
                    meas_valid = 1'b1;
                    sent       = 1'b1;
                    e = model(int'(meas_ch), chv[meas_ch], chi[meas_ch]);
                    sb.push_back(e);
                end else if (!sent) begin
                    meas_valid = 1'b0;
                end
                lat++;
            end else begin
                lat = 0;
                sent = 1'b0;
                meas_valid = 1'($urandom_range(0, 1));
                voltage = 16'($urandom);
                current = 16'($urandom);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (soc_valid && rst_n) begin
                check("sb_pending", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("soc_ch", soc_ch, e.ch);
                    check("soc", soc, e.soc);
                    check("soc_mode", soc_mode, e.mode);
                end
                n_out[soc_ch]++;
                last_soc[soc_ch]  = int'(soc);
                last_mode[soc_ch] = int'(soc_mode);
            end
        end
    end

    task automatic run_scan(input string name);
        int n3;
        bit done;
        n3 = n_out[3];
        done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            if (n_out[3] != n3) done = 1'b1;
        end
        check(name, done, 1);
    endtask

    initial begin : main
        phase_t ph [9];
        int     n2;
        bit     got;
        ph[0] = '{1,  32768,    0,  50, 1};
        ph[1] = '{10, 32768,  140,  60, 0};
        ph[2] = '{70, 32768, -140,   0, 0};
        ph[3] = '{30, 64900,    3,   0, 0};
        ph[4] = '{1,  64900,   50,   1, 0};
        ph[5] = '{99, 64900,    3,   3, 0};
        ph[6] = '{1,  64900,    3,  99, 1};
        ph[7] = '{1,  64900, 1000, 100, 0};
        ph[8] = '{3,  64900, 1000, 100, 0};
        chv[1] = 40000; chi[1] = 1000;
        chv[2] = 20000; chi[2] = 0;
        chv[3] = 65535; chi[3] = -2000;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {meas_req, meas_ch, soc_valid, soc_ch, soc, soc_mode, fault, overrun}, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_after_reset", {meas_req, soc_valid, fault, overrun}, 0);

        for (int p = 0; p < 9; p++) begin
            chv[0] = ph[p].v0;
            chi[0] = ph[p].i0;
            for (int t = 0; t < ph[p].ticks; t++) begin
                run_scan("scan_done");
                if (p == 0) begin
                    check("esr_ch1_soc", last_soc[1], 59);
                    check("esr_ch1_mode", last_mode[1], 1);
                    check("ch2_init_soc", last_soc[2], 30);
                    check("ch3_clamp_soc", last_soc[3], 100);
                    chi[1] = 0;
                end
                if (p == 1) check("ch0_ramp", last_soc[0], 51 + t);
            end
            check($sformatf("phase%0d_soc", p), last_soc[0], ph[p].exp_soc);
            check($sformatf("phase%0d_mode", p), last_mode[0], ph[p].exp_mode);
        end

        check("no_fault_yet", fault, 0);
        check("no_overrun_yet", overrun, 0);
        check("sb_drained", sb.size(), 0);

        dead[2] = 1'b1;
        dead_cycles = 0;
        n2 = n_out[2];
        run_scan("fault_scan1");
        check("timeout_cycles", dead_cycles, 255);
        check("fault_flags", fault, 4'b0100);
        check("overrun_set", overrun, 1);
        run_scan("fault_scan2");
        check("ch2_no_strobe", n_out[2], n2);
        check("timeout_cycles2", dead_cycles, 510);
        check("sb_drained2", sb.size(), 0);

        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (meas_req) got = 1'b1;
        end
        check("req_before_abort", got, 1);
        rst_n = 1'b0;
        #1;
        check("abort_on_reset", {meas_req, soc_valid, fault, overrun}, 0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_estimator_mc.md
Name: soc_estimator_mc

Overview:
Multi-channel, parametrised state-of-charge estimator for a bank of NUM_CH storage cells. Once per 1 ms tick it scans each channel in turn through a request/response handshake with the shared ADC front-end. Per channel it applies ESR compensation, then does one of two things: coulomb counting into a saturating charge accumulator, or recalibration from voltage after a programmable rest dwell. A 0-100 % result is emitted per channel with a valid strobe for the BMS supervisor.

Parameters:
NUM_CH, 4, number of channels scanned per tick (1-16); CH_W = max(1, clog2(NUM_CH))
V_W, 16, voltage code width (unsigned)
I_W, 16, current code width (signed, 0.1 A units, positive = charging)
ACC_W, 32, per-channel charge accumulator width
CLK_DIV, 50000, clk cycles per tick (1 ms at 50 MHz)
SOC_SCALE, 14000, accumulator counts per 1 % SoC
I_GAIN, 100, accumulator counts added per current LSB per tick
I_THRESH, 5, rest threshold; rest when |current| <= I_THRESH
REST_TICKS, 100, consecutive rest ticks before voltage recalibration
ESR_MILLI, 1000, ESR correction; v_comp = voltage - current*ESR_MILLI/1000
V_MIN, 0, voltage code mapping to 0 %
V_MAX, 65535, voltage code mapping to 100 % (V_MAX > V_MIN)
TIMEOUT, 255, max clk cycles to wait for meas_valid

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
meas_req  out  1  request a sample for channel meas_ch; held until accepted
meas_ch  out  CH_W  channel being requested
meas_valid  in  1  front-end response strobe; sample accepted when meas_req & meas_valid
voltage  in  V_W  channel voltage code, sampled on acceptance
current  in  I_W  signed channel current, sampled on acceptance
soc_valid  out  1  one-cycle strobe: soc/soc_ch/soc_mode valid
soc_ch  out  CH_W  channel of current result
soc  out  8  SoC percent, 0..100
soc_mode  out  1  1 = result from voltage calibration, 0 = coulomb count
fault  out  NUM_CH  sticky per-channel timeout flag
overrun  out  1  sticky: tick arrived while a scan was still running

Behaviour:
- Reset: all outputs 0; tick counter 0; FSM IDLE; per-channel acc=0, rest_cnt=0, init=0. Reset mid-scan aborts immediately; no partial write.
- Tick: counter wraps at CLK_DIV-1; tick pulses on the wrap cycle.
- FSM: IDLE -> REQ on tick (ch=0).
- REQ: meas_req=1, meas_ch=ch. On accept, latch the sample and go to COMP. If TIMEOUT cycles pass without accept, set fault[ch], drop the request, leave that channel's state unchanged, emit no result, and go to NEXT.
- COMP: compute v_comp signed with width V_W+I_W+11, clamp to [V_MIN, V_MAX]. rest = (|current| <= I_THRESH); rest_cnt saturates at REST_TICKS and clears on non-rest.
- UPDATE:
  - If init==0, or rest and rest_cnt reached REST_TICKS: soc_v = floor((v_comp-V_MIN)*100/(V_MAX-V_MIN)), acc = soc_v*SOC_SCALE, mode=1, init=1.
  - Otherwise: acc += current*I_GAIN, computed signed at ACC_W+1 bits, saturated to [0, 100*SOC_SCALE]; mode=0.
  - During a rest dwell that has not yet reached REST_TICKS the current is still counted.
- DIV: soc = floor(acc/SOC_SCALE), using a sequential restoring divider of at most 8 iterations; the voltage path uses the same divider. Result is exact floor and never exceeds 100.
- OUT: soc_valid=1 for one cycle with soc_ch=ch and soc_mode. soc and soc_mode hold until the next strobe.
- NEXT: if ch==NUM_CH-1 go to IDLE, else ch+1 and go to REQ.
- Overrun: a tick seen outside IDLE sets overrun; that tick is discarded and the in-flight scan completes normally.
- meas_valid seen while meas_req=0 is ignored.
- fault and overrun clear only on reset.
- Worst-case scan of NUM_CH*(TIMEOUT+20) cycles must fit in CLK_DIV.

Test Plan:
- Reset release, first tick, ch0 voltage=32768, current=0 -> soc_valid with soc_ch=0, soc=50, soc_mode=1; channels 1-3 strobe in order 1,2,3 within the same scan.
- ch0 initialised at 50 %, then current=+140 for 10 ticks -> soc 51,52,...,60 with soc_mode=0; current=-140 for 70 ticks -> saturates at soc=0; acc never negative.
- Charging from 99 % with current=+1000 -> soc=100 clamped and stays 100 on subsequent ticks.
- current=3 (within threshold) for 99 ticks -> soc_mode=0; at tick 100 -> soc_mode=1 with soc re-derived from voltage. A single tick of current=50 mid-dwell restarts the count.
- ESR check: voltage=40000, current=+1000, ESR_MILLI=1000, first tick -> v_comp=39000 and soc=59.
- Front-end never asserts meas_valid for ch2 -> after 255 cycles fault[2]=1, no strobe for ch2, ch3 still processed. With CLK_DIV set to 100 -> overrun=1, scans still complete in channel order.
